ld_seq: RTL and testbench

//  Multicycle load sequencer for the load-class opcodes 0x10-0x14 (immediate, direct, indirect,

---
 rtl/ld_seq_if.sv | 41 ++++
 rtl/ld_seq.sv | 195 +++++++++++++++++++
 tb/tb_ld_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ld_seq_if.sv
// Bundle between the load sequencer, the instruction/register-file side and data memory.
// Latency: none; pure wiring.
// Backpressure: mem_req/mem_ack handshake toward memory, stall toward the PC.
interface ld_seq_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  // instruction fields
  logic          valid;
  logic [7:0]    opcode;
  logic [AW-1:0] imm;
  logic [3:0]    rs;
  logic [3:0]    rd;
  // register-file read port
  logic [3:0]    rf_raddr;
  logic [DW-1:0] rf_rdata;
  // data-memory read handshake
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  // control / writeback
  logic          stall;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          err;

  // sequencer side
  modport master (
    input  valid, opcode, imm, rs, rd, rf_rdata, mem_rdata, mem_ack,
    output rf_raddr, mem_req, mem_addr, stall, wr_en, wr_addr, wr_data, busy, err
  );

  // instruction source, register file and memory side
  modport slave (
    output valid, opcode, imm, rs, rd, rf_rdata, mem_rdata, mem_ack,
    input  rf_raddr, mem_req, mem_addr, stall, wr_en, wr_addr, wr_data, busy, err
  );
endinterface

// File: rtl/ld_seq.sv
// Multicycle load sequencer for opcodes 0x10-0x14, one register writeback (or error pulse) per load.
// Latency accept->wr_en: 1 (imm/reg), 2 (direct/relative), 4 (indirect) with zero-wait memory.
// Backpressure: stall holds the PC while reads are pending; each read waits at most TIMEOUT cycles for mem_ack.
module ld_seq #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     reset,
  ld_seq_if.master bus
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [7:0] OP_IMM = 8'h10;
  localparam logic [7:0] OP_DIR = 8'h11;
  localparam logic [7:0] OP_IND = 8'h12;
  localparam logic [7:0] OP_REG = 8'h13;
  localparam logic [7:0] OP_REL = 8'h14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_PLO,
    S_RD_PHI,
    S_RD_DATA,
    S_WB,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   imm_q, imm_d;
  logic [3:0]      rd_q, rd_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [DW-1:0]   data_q, data_d;
  logic [AW-1:0]   addr_d;

  logic            mem_req_q;
  logic [AW-1:0]   mem_addr_q;
  logic            wr_en_q;
  logic [3:0]      wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic            err_q;

  logic            is_load;
  logic            accept;
  logic            in_rd_q;
  logic            in_rd_d;
  logic [2*DW-1:0] ptr;
  logic [AW-1:0]   rel_addr;

  assign is_load  = (bus.opcode >= OP_IMM) && (bus.opcode <= OP_REL);
  assign accept   = bus.valid && is_load;
  assign in_rd_q  = (state_q == S_RD_PLO) || (state_q == S_RD_PHI) || (state_q == S_RD_DATA);
  assign in_rd_d  = (state_d == S_RD_PLO) || (state_d == S_RD_PHI) || (state_d == S_RD_DATA);

  // Pointer assembled from the stored low byte and the high byte arriving now.
  assign ptr      = {bus.mem_rdata, lo_q};
  // Relative address wraps naturally at the AW-bit boundary.
  assign rel_addr = bus.imm + AW'(bus.rf_rdata);

  // Next-state, datapath capture and per-read timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    lo_d    = lo_q;
    data_d  = data_q;
    addr_d  = mem_addr_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          imm_d = bus.imm;
          rd_d  = bus.rd;
          cnt_d = '0;
          case (bus.opcode)
            OP_IMM: begin
              data_d  = bus.imm[DW-1:0];
              state_d = S_WB;
            end
            OP_REG: begin
              data_d  = bus.rf_rdata;
              state_d = S_WB;
            end
            OP_DIR: begin
              addr_d  = bus.imm;
              state_d = S_RD_DATA;
            end
            OP_REL: begin
              addr_d  = rel_addr;
              state_d = S_RD_DATA;
            end
            OP_IND: begin
              addr_d  = bus.imm;
              state_d = S_RD_PLO;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RD_PLO: begin
        if (bus.mem_ack) begin
          lo_d    = bus.mem_rdata;
          addr_d  = imm_q + AW'(1);
          cnt_d   = '0;
          state_d = S_RD_PHI;
        end
      end
      S_RD_PHI: begin
        if (bus.mem_ack) begin
          addr_d  = AW'(ptr);
          cnt_d   = '0;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.mem_ack) begin
          data_d  = bus.mem_rdata;
          state_d = S_WB;
        end
      end
      // WB and ERR last exactly one cycle.
      default: state_d = S_IDLE;
    endcase

    // A read that sees no ack in its last allowed cycle abandons the load; an ack in that cycle wins.
    if (in_rd_q && !bus.mem_ack) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_ERR;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched instruction fields and intermediate load data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imm_q  <= '0;
      rd_q   <= '0;
      lo_q   <= '0;
      data_q <= '0;
    end else begin
      imm_q  <= imm_d;
      rd_q   <= rd_d;
      lo_q   <= lo_d;
      data_q <= data_d;
    end
  end

  // Registered outputs, computed from the state being entered so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_req_q  <= in_rd_d;
      mem_addr_q <= addr_d;
      wr_en_q    <= (state_d == S_WB);
      wr_addr_q  <= (state_d == S_WB) ? rd_d : '0;
      wr_data_q  <= (state_d == S_WB) ? data_d : '0;
      err_q      <= (state_d == S_ERR);
    end
  end

  assign bus.rf_raddr = bus.rs;
  assign bus.stall    = ((state_q == S_IDLE) && accept) || in_rd_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ld_seq.sv
// Bench for ld_seq: directed loads plus randomized loads against a behavioural model.
// Latency: checks accept-to-writeback cycle counts for each addressing mode.
// Backpressure: acts as data memory with programmable ack delay, including never-ack timeouts.
module tb_ld_seq;
  localparam int AW      = 16;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;
  localparam int NO_ACK  = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ld_seq_if #(.AW(AW), .DW(DW)) bus ();

  ld_seq #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] rf  [0:15];

  assign bus.rf_rdata = rf[bus.rf_raddr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete load: model computes the address sequence and result, bench plays memory.
  task automatic run_load(input logic [7:0] op, input logic [15:0] iv, input logic [3:0] rsv,
                          input logic [3:0] rdv, input int dly);
    logic [15:0] q[$];
    logic [15:0] a, ip1;
    logic [7:0]  exp_d;
    int          nreq, lat, w, reqcyc;
    bit          done, expect_err;

    ip1 = iv + 16'd1;
    case (op)
      8'h10: exp_d = iv[7:0];
      8'h13: exp_d = rf[rsv];
      8'h11: begin q.push_back(iv); exp_d = mem[iv]; end
      8'h14: begin a = iv + {8'h00, rf[rsv]}; q.push_back(a); exp_d = mem[a]; end
      default: begin
        a = {mem[ip1], mem[iv]};
        q.push_back(iv); q.push_back(ip1); q.push_back(a);
        exp_d = mem[a];
      end
    endcase
    nreq       = q.size();
    expect_err = (nreq != 0) && (dly >= TIMEOUT);

    @(negedge clk);
    chk("idle_wr_en", bus.wr_en, 0);
    chk("idle_err", bus.err, 0);
    chk("idle_busy", bus.busy, 0);
    bus.valid = 1'b1; bus.opcode = op; bus.imm = iv; bus.rs = rsv; bus.rd = rdv;
    #1;
    chk("accept_stall", bus.stall, 1);
    chk("rf_raddr", bus.rf_raddr, rsv);
    @(negedge clk);
    // scramble the fields to show the sequencer works from its own copies
    bus.valid = 1'b0; bus.opcode = 8'h00; bus.imm = 16'($urandom); bus.rd = 4'($urandom);
    lat = 1; w = 0; reqcyc = 0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (bus.wr_en || bus.err) begin
        done = 1'b1;
        chk("err_pulse", bus.err, expect_err);
        chk("wr_en", bus.wr_en, !expect_err);
        chk("stall_end", bus.stall, 0);
        chk("mem_req_end", bus.mem_req, 0);
        if (expect_err) begin
          chk("req_cycles", reqcyc, TIMEOUT);
        end else begin
          chk("wr_addr", bus.wr_addr, rdv);
          chk("wr_data", bus.wr_data, exp_d);
          chk("latency", lat, 1 + nreq * (dly + 1));
          chk("reqs_left", q.size(), 0);
        end
      end else begin
        chk("mem_req", bus.mem_req, q.size() != 0);
        chk("stall_rd", bus.stall, 1);
        chk("busy_rd", bus.busy, 1);
        if (q.size() != 0) begin
          chk("mem_addr", bus.mem_addr, q[0]);
          reqcyc++;
          if (w == dly) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[q[0]];
            void'(q.pop_front());
            w = 0; reqcyc = 0;
          end else begin
            w++;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'($urandom);
          end
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        lat++;
      end
    end
    chk("finished", done, 1);
  endtask

  initial begin
    logic [7:0]  rop;
    logic [15:0] riv;
    int          rdly;

    reset = 1'b0;
    bus.valid = 1'b0; bus.opcode = 8'h00; bus.imm = '0; bus.rs = '0; bus.rd = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);

    // reset state
    #12;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall, 0);
    @(negedge clk);
    reset = 1'b1;

    // immediate load
    run_load(8'h10, 16'h0042, 4'd0, 4'd3, 0);
    // direct load, ack after three waits
    mem[16'h0200] = 8'h5A;
    run_load(8'h11, 16'h0200, 4'd0, 4'd7, 3);
    // indirect load
    mem[16'h0100] = 8'h34; mem[16'h0101] = 8'h12; mem[16'h1234] = 8'hAB;
    run_load(8'h12, 16'h0100, 4'd0, 4'd9, 0);
    // relative load wrapping past 0xFFFF
    rf[5] = 8'h20; mem[16'h0010] = 8'h77;
    run_load(8'h14, 16'hFFF0, 4'd5, 4'd1, 1);
    // register-direct load
    run_load(8'h13, 16'h1111, 4'd5, 4'd2, 0);
    // direct load that never completes, then a load right after the abort
    run_load(8'h11, 16'h0200, 4'd0, 4'd6, NO_ACK);
    run_load(8'h10, 16'h00C3, 4'd0, 4'd4, 0);
    // indirect pointer read at 0xFFFF wraps to 0x0000
    run_load(8'h12, 16'hFFFF, 4'd0, 4'd8, 2);

    // non-load opcodes and valid=0 are ignored
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.valid  = (i != 5);
      bus.opcode = (i == 5) ? 8'h11 : ((i % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(21, 255)));
      #1;
      chk("nonload_stall", bus.stall, 0);
      @(negedge clk);
      chk("nonload_busy", bus.busy, 0);
      chk("nonload_req", bus.mem_req, 0);
      bus.valid = 1'b0;
    end

    // reset in the middle of an indirect load's pointer-high read
    @(negedge clk);
    bus.valid = 1'b1; bus.opcode = 8'h12; bus.imm = 16'h0300; bus.rd = 4'd11;
    @(negedge clk);
    bus.valid = 1'b0; bus.opcode = 8'h00;
    chk("mid_req_lo", bus.mem_addr, 16'h0300);
    bus.mem_ack = 1'b1; bus.mem_rdata = mem[16'h0300];
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("mid_req_hi", bus.mem_addr, 16'h0301);
    chk("mid_req_hi_vld", bus.mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req", bus.mem_req, 0);
    chk("mid_rst_addr", bus.mem_addr, 0);
    chk("mid_rst_wr_en", bus.wr_en, 0);
    chk("mid_rst_wr_data", bus.wr_data, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_stall", bus.stall, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ack = 1'b1; bus.mem_rdata = 8'($urandom);
      @(negedge clk);
      chk("post_rst_wr_en", bus.wr_en, 0);
      chk("post_rst_busy", bus.busy, 0);
    end
    bus.mem_ack = 1'b0;

    // randomized loads
    for (int i = 0; i < 40; i++) begin
      rop  = 8'h10 + 8'($urandom_range(0, 4));
      riv  = 16'($urandom);
      rdly = ($urandom_range(0, 9) == 0) ? NO_ACK : int'($urandom_range(0, 3));
      run_load(rop, riv, 4'($urandom), 4'($urandom), rdly);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard stop in case something stalls the stimulus
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
